mem_arbiter: RTL and testbench

- Shares one synchronous single-port SRAM between the core's instruction-fetch port and data-access port.
- Sits between the fetch/data interfaces of the multicycle core and the unified memory macro.
- Arbitrates per cycle, with data priority and a bounded-starvation guarantee for fetch.
- Tracks the single outstanding 1-cycle-latency access so that each response is routed to the port that issued it.

---
 rtl/mem_arbiter.sv | 100 ++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port SRAM arbiter between instruction fetch and data access.
// Data has priority; fetch is forced through after StarveLimit consecutive data grants.
module mem_arbiter #(
  parameter int MemAw       = 12,
  parameter int StarveLimit = 4
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             i_req_valid,
  output logic             i_req_ready,
  input  logic [31:0]      i_addr,
  output logic             i_rsp_valid,
  output logic [31:0]      i_rdata,

  input  logic             d_req_valid,
  output logic             d_req_ready,
  input  logic [31:0]      d_addr,
  input  logic             d_we,
  input  logic [3:0]       d_wstrb,
  input  logic [31:0]      d_wdata,
  output logic             d_rsp_valid,
  output logic [31:0]      d_rdata,

  output logic             m_en,
  output logic [3:0]       m_wstrb,
  output logic [MemAw-1:0] m_addr,
  output logic [31:0]      m_wdata,
  input  logic [31:0]      m_rdata
);

  localparam logic [3:0] STARVE_MAX = 4'(StarveLimit);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_I,
    OWN_D
  } owner_e;

  owner_e     rsp_owner_q, rsp_owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       i_gnt, d_gnt, fetch_forced;

  // Byte-offset and above-SRAM address bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:MemAw+2], i_addr[1:0],
                              d_addr[31:MemAw+2], d_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_owner_q  <= OWN_NONE;
      starve_cnt_q <= '0;
    end else begin
      rsp_owner_q  <= rsp_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    fetch_forced = i_req_valid && (starve_cnt_q == STARVE_MAX);
    d_gnt        = reset && d_req_valid && !fetch_forced;
    i_gnt        = reset && i_req_valid && !d_gnt;

    starve_cnt_d = '0;
    if (d_gnt && i_req_valid) begin
      starve_cnt_d = (starve_cnt_q == STARVE_MAX) ? STARVE_MAX : starve_cnt_q + 4'd1;
    end

    rsp_owner_d = OWN_NONE;
    if (i_gnt) begin
      rsp_owner_d = OWN_I;
    end else if (d_gnt) begin
      rsp_owner_d = OWN_D;
    end
  end

  always_comb begin
    i_req_ready = i_gnt;
    d_req_ready = d_gnt;
    m_en        = i_gnt || d_gnt;
    m_wstrb     = '0;
    m_addr      = '0;
    m_wdata     = '0;
    if (i_gnt) begin
      m_addr = i_addr[MemAw+1:2];
    end else if (d_gnt) begin
      m_addr  = d_addr[MemAw+1:2];
      m_wdata = d_wdata;
      m_wstrb = d_we ? d_wstrb : 4'b0000;
    end

    // Gating with reset kills the response of an access granted just before reset.
    i_rsp_valid = reset && (rsp_owner_q == OWN_I);
    d_rsp_valid = reset && (rsp_owner_q == OWN_D);
  end

  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked against
// a transaction-level model (shadow memory, pending-response record, data streak).
module tb_mem_arbiter;
  localparam int MemAw       = 12;
  localparam int StarveLimit = 4;
  localparam int Words       = 1 << MemAw;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             i_req_valid, i_req_ready, i_rsp_valid;
  logic [31:0]      i_addr, i_rdata;
  logic             d_req_valid, d_req_ready, d_we, d_rsp_valid;
  logic [31:0]      d_addr, d_wdata, d_rdata;
  logic [3:0]       d_wstrb;
  logic             m_en;
  logic [3:0]       m_wstrb;
  logic [MemAw-1:0] m_addr;
  logic [31:0]      m_wdata, m_rdata;

  mem_arbiter #(.MemAw(MemAw), .StarveLimit(StarveLimit)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_wstrb(d_wstrb), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
    .m_en(m_en), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int k);
    if (k == 4) return 32'hDEAD_BEEF;
    if (k == 8) return 32'hAAAA_AAAA;
    return {16'hC0DE, 16'(k * 37)};
  endfunction

  // SRAM macro: 1-cycle read latency, byte-enabled writes.
  logic [31:0] sram [Words];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_wstrb == 4'b0000) begin
        m_rdata <= sram[m_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (m_wstrb[b]) sram[m_addr][b*8 +: 8] <= m_wdata[b*8 +: 8];
        end
      end
    end
  end

  logic [31:0] model_mem [Words];
  int          pend_kind;   // 0 none, 1 fetch, 2 data
  logic        pend_rd;
  logic [31:0] pend_data;
  int          streak;
  int          n_igr;
  logic [31:0] last_i_rdata, last_d_rdata;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] ia, input logic dv,
                       input logic [31:0] da, input logic we, input logic [3:0] ws,
                       input logic [31:0] wd);
    i_req_valid = iv;
    i_addr      = ia;
    d_req_valid = dv;
    d_addr      = da;
    d_we        = we;
    d_wstrb     = ws;
    d_wdata     = wd;
  endtask

  task automatic step();
    int          g;
    int          wa;
    logic [3:0]  ws;
    @(negedge clk);
    if (!reset) begin
      check("rst_i_req_ready", {31'd0, i_req_ready}, 32'd0);
      check("rst_d_req_ready", {31'd0, d_req_ready}, 32'd0);
      check("rst_i_rsp_valid", {31'd0, i_rsp_valid}, 32'd0);
      check("rst_d_rsp_valid", {31'd0, d_rsp_valid}, 32'd0);
      check("rst_m_en", {31'd0, m_en}, 32'd0);
      check("rst_m_wstrb", {28'd0, m_wstrb}, 32'd0);
      pend_kind = 0;
      streak    = 0;
    end else begin
      check("i_rsp_valid", {31'd0, i_rsp_valid}, (pend_kind == 1) ? 32'd1 : 32'd0);
      check("d_rsp_valid", {31'd0, d_rsp_valid}, (pend_kind == 2) ? 32'd1 : 32'd0);
      if (pend_kind == 1) begin
        check("i_rdata", i_rdata, pend_data);
        last_i_rdata = i_rdata;
      end
      if (pend_kind == 2 && pend_rd) begin
        check("d_rdata", d_rdata, pend_data);
        last_d_rdata = d_rdata;
      end

      if (i_req_valid && d_req_valid) g = (streak >= StarveLimit) ? 1 : 2;
      else if (i_req_valid)           g = 1;
      else if (d_req_valid)           g = 2;
      else                            g = 0;

      check("i_req_ready", {31'd0, i_req_ready}, (g == 1) ? 32'd1 : 32'd0);
      check("d_req_ready", {31'd0, d_req_ready}, (g == 2) ? 32'd1 : 32'd0);
      check("m_en", {31'd0, m_en}, (g != 0) ? 32'd1 : 32'd0);

      if (g == 1) begin
        wa = int'((i_addr >> 2) % Words);
        check("m_addr_fetch", 32'(m_addr), 32'(wa));
        check("m_wstrb_fetch", {28'd0, m_wstrb}, 32'd0);
        pend_kind = 1;
        pend_data = model_mem[wa];
        n_igr++;
      end else if (g == 2) begin
        wa = int'((d_addr >> 2) % Words);
        ws = d_we ? d_wstrb : 4'b0000;
        check("m_addr_data", 32'(m_addr), 32'(wa));
        check("m_wstrb_data", {28'd0, m_wstrb}, {28'd0, ws});
        check("m_wdata", m_wdata, d_wdata);
        pend_kind = 2;
        pend_rd   = !d_we;
        if (d_we) begin
          for (int b = 0; b < 4; b++) begin
            if (ws[b]) model_mem[wa][b*8 +: 8] = d_wdata[b*8 +: 8];
          end
        end else begin
          pend_data = model_mem[wa];
        end
      end else begin
        check("m_wstrb_idle", {28'd0, m_wstrb}, 32'd0);
        check("m_addr_idle", 32'(m_addr), 32'd0);
        check("m_wdata_idle", m_wdata, 32'd0);
        pend_kind = 0;
      end

      if (g == 2 && i_req_valid) streak++;
      else                       streak = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    for (int k = 0; k < Words; k++) begin
      sram[k]      <= init_word(k);
      model_mem[k]  = init_word(k);
    end
    pend_kind = 0;
    pend_rd   = 1'b0;
    pend_data = '0;
    streak    = 0;
    n_igr     = 0;
    drive(1'b1, 32'h0, 1'b1, 32'h0, 1'b0, 4'h0, 32'h0);

    // Reset held with both requests asserted: nothing may be granted.
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    step();

    // Single fetch of word 4.
    last_i_rdata = 'x;
    drive(1'b1, 32'h0000_0010, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    step();
    check("t1_fetch_data", last_i_rdata, 32'hDEAD_BEEF);

    // Partial write then read-back of word 8.
    last_d_rdata = 'x;
    drive(1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 4'b0011, 32'h1234_5678);
    step();
    drive(1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 4'b0000, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    step();
    check("t2_read_after_write", last_d_rdata, 32'hAAAA_5678);

    // Both ports busy: fetch gets one slot in every five.
    base = n_igr;
    for (int c = 0; c < 15; c++) begin
      drive(1'b1, 32'(c * 4), 1'b1, 32'(c * 8 + 256), 1'b0, 4'h0, 32'h0);
      step();
    end
    check("t3_fetch_share", 32'(n_igr - base), 32'd3);

    // Alternating fetch and data reads.
    for (int c = 0; c < 6; c++) begin
      if (c % 2 == 0) drive(1'b1, 32'(c * 4 + 64), 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
      else            drive(1'b0, 32'h0, 1'b1, 32'(c * 4 + 128), 1'b0, 4'hF, 32'h0);
      step();
    end

    // Address wrap: 0x4004 aliases word 1.
    drive(1'b0, 32'h0, 1'b1, 32'h0000_4004, 1'b1, 4'hF, 32'h5555_0001);
    step();
    last_d_rdata = 'x;
    drive(1'b0, 32'h0, 1'b1, 32'h0000_0004, 1'b0, 4'h0, 32'h0);
    step();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    step();
    check("t5_wrap_alias", last_d_rdata, 32'h5555_0001);

    // Reset right after a fetch grant, with a data streak built up first.
    drive(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 4'h0, 32'h0);
    step();
    step();
    drive(1'b1, 32'h44, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    step();
    reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    step();
    reset = 1'b1;
    base = n_igr;
    drive(1'b1, 32'h48, 1'b1, 32'h84, 1'b0, 4'h0, 32'h0);
    for (int c = 0; c < 4; c++) step();
    check("t6_no_early_fetch", 32'(n_igr - base), 32'd0);
    step();
    check("t6_fetch_on_fifth", 32'(n_igr - base), 32'd1);

    // Random traffic with occasional reset pulses.
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 49) != 0);
      drive(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 2) != 0),
            $urandom(), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom());
      step();
    end

    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
